// File: rtl/fir_axis_frame_source.sv
// rtl/fir_axis_frame_source.sv - AXIS frame transmitter that streams a preloaded sample buffer into the FIR filter (optional feature macro: FIR_SRC_REPEAT_EN)
module fir_axis_frame_source #(
    parameter int AXIS_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [AXIS_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH:0]   frame_len,
    input  logic                  start,
`ifdef FIR_SRC_REPEAT_EN
    input  logic                  repeat_mode,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = '0;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   index;
    logic [ADDR_WIDTH:0]     len;
    logic [AXIS_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   idx_next;
    logic                    next_is_last;
    logic                    wr_ok;
    logic                    start_ok;
    logic                    handshake;

    // Writes only land while idle so an in-flight frame never changes under the reader.
    assign wr_ok        = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);
    assign start_ok     = start && (frame_len != '0) && (frame_len <= DEPTH_W);
    assign handshake    = m_axis_tvalid && m_axis_tready;
    assign idx_next     = index + IDX_ONE;
    assign next_is_last = ({1'b0, idx_next} == (len - LEN_ONE));

    // Sample buffer: synchronous write port, contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Frame sequencer; the buffer read feeds the tdata/tlast output register directly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            index         <= '0;
            len           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len   <= frame_len;
                        index <= '0;
                        busy  <= 1'b1;
                        state <= ST_PREFETCH;
                    end
                end
                ST_PREFETCH: begin
                    m_axis_tdata  <= mem[IDX_ZERO];
                    m_axis_tlast  <= (len == LEN_ONE);
                    m_axis_tvalid <= 1'b1;
                    state         <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (handshake) begin
                        if (!m_axis_tlast) begin
                            index        <= idx_next;
                            m_axis_tdata <= mem[idx_next];
                            m_axis_tlast <= next_is_last;
                        end else begin
                            done <= 1'b1;
`ifdef FIR_SRC_REPEAT_EN
                            if (repeat_mode) begin
                                // Wrap straight back to the first sample so frames run gapless.
                                index        <= '0;
                                m_axis_tdata <= mem[IDX_ZERO];
                                m_axis_tlast <= (len == LEN_ONE);
                            end else begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                busy          <= 1'b0;
                                state         <= ST_IDLE;
                            end
`else
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            busy          <= 1'b0;
                            state         <= ST_IDLE;
`endif
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    busy          <= 1'b0;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_axis_frame_source.sv
// tb/tb_fir_axis_frame_source.sv - directed self-checking bench for fir_axis_frame_source
module tb_fir_axis_frame_source;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [8:0]  frame_len;
    logic        start;
    logic        busy;
    logic        done;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] m_axis_tdata;
`ifdef FIR_SRC_REPEAT_EN
    logic        repeat_mode;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [15:0] exp_data [0:15];

    always #5 clk = ~clk;

    fir_axis_frame_source #(
        .AXIS_WIDTH(16),
        .DEPTH(256),
        .ADDR_WIDTH(8)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_len(frame_len),
        .start(start),
`ifdef FIR_SRC_REPEAT_EN
        .repeat_mode(repeat_mode),
`endif
        .busy(busy),
        .done(done),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tdata(m_axis_tdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic [8:0] l);
        frame_len = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int c = 0;
        while (!m_axis_tvalid && c < 20) begin
            step();
            c++;
        end
        chk(tag, 32'(m_axis_tvalid), 32'd1);
    endtask

    // pat 0: tready always 1; pat 1: tready 1,0,0,1,0,0,...
    task automatic run_frame(input int n, input int pat, input string tag);
        int          beats = 0;
        int          cyc   = 0;
        bit          fin   = 1'b0;
        logic [15:0] hd;
        logic        hl;
        while (!fin && cyc < 200) begin
            m_axis_tready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (m_axis_tvalid) begin
                if (m_axis_tready) begin
                    chk({tag, "_data"}, 32'(m_axis_tdata), 32'(exp_data[beats]));
                    chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'(beats == n - 1));
                    beats++;
                    step();
                    cyc++;
                    if (beats == n) begin
                        chk({tag, "_done"}, 32'(done), 32'd1);
                        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
                        chk({tag, "_tvalid_low"}, 32'(m_axis_tvalid), 32'd0);
                        fin = 1'b1;
                    end else begin
                        chk({tag, "_nobubble"}, 32'(m_axis_tvalid), 32'd1);
                    end
                end else begin
                    hd = m_axis_tdata;
                    hl = m_axis_tlast;
                    step();
                    cyc++;
                    chk({tag, "_hold_valid"}, 32'(m_axis_tvalid), 32'd1);
                    chk({tag, "_hold_data"}, 32'(m_axis_tdata), 32'(hd));
                    chk({tag, "_hold_tlast"}, 32'(m_axis_tlast), 32'(hl));
                end
            end else begin
                step();
                cyc++;
            end
        end
        chk({tag, "_beat_count"}, 32'(beats), 32'(n));
        m_axis_tready = 1'b1;
    endtask

    initial begin
        resetn        = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        frame_len     = '0;
        start         = 1'b0;
        m_axis_tready = 1'b1;
`ifdef FIR_SRC_REPEAT_EN
        repeat_mode   = 1'b0;
`endif
        step();
        step();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        resetn = 1'b1;
        step();

        // Test 1: eight samples, tready held high
        for (int i = 0; i < 8; i++) begin
            wr(8'(i), 16'(i + 1));
            exp_data[i] = 16'(i + 1);
        end
        do_start(9'd8);
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        chk("t1_tvalid_prefetch", 32'(m_axis_tvalid), 32'd0);
        step();
        chk("t1_tvalid_latency", 32'(m_axis_tvalid), 32'd1);
        chk("t1_first_data", 32'(m_axis_tdata), 32'd1);
        run_frame(8, 0, "t1");
        step();
        chk("t1_done_one_cycle", 32'(done), 32'd0);

        // Test 2: same frame under backpressure
        do_start(9'd8);
        run_frame(8, 1, "t2");
        step();

        // Test 3: single-beat frame, then illegal lengths
        wr(8'd0, 16'h7FFF);
        exp_data[0] = 16'h7FFF;
        do_start(9'd1);
        run_frame(1, 0, "t3");
        step();
        do_start(9'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_len0_tvalid", 32'(m_axis_tvalid), 32'd0);
            chk("t3_len0_done", 32'(done), 32'd0);
            chk("t3_len0_busy", 32'(busy), 32'd0);
            step();
        end
        do_start(9'd257);
        for (int i = 0; i < 4; i++) begin
            chk("t3_len257_tvalid", 32'(m_axis_tvalid), 32'd0);
            chk("t3_len257_done", 32'(done), 32'd0);
            chk("t3_len257_busy", 32'(busy), 32'd0);
            step();
        end

        // Test 4: start and write while busy are ignored, then reset mid-frame
        wr(8'd0, 16'd1);
        do_start(9'd8);
        wait_valid("t4_valid");
        for (int k = 0; k < 3; k++) begin
            chk("t4_beat", 32'(m_axis_tdata), 32'(k + 1));
            step();
        end
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 8'd5;
        wr_data = 16'hDEAD;
        chk("t4_beat4", 32'(m_axis_tdata), 32'd4);
        step();
        start   = 1'b0;
        wr_en   = 1'b0;
        chk("t4_beat5", 32'(m_axis_tdata), 32'd5);
        chk("t4_busy_kept", 32'(busy), 32'd1);
        step();
        chk("t4_beat6_original", 32'(m_axis_tdata), 32'd6);
        resetn = 1'b0;
        #1;
        chk("t4_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t4_rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_done", 32'(done), 32'd0);
        step();
        resetn = 1'b1;
        step();
        chk("t4_idle_after_rst", 32'(m_axis_tvalid), 32'd0);

`ifdef FIR_SRC_REPEAT_EN
        // Test 5: gapless repeated frames, then a normal finish
        wr(8'd0, 16'd10);
        wr(8'd1, 16'd20);
        wr(8'd2, 16'd30);
        wr(8'd3, 16'd40);
        exp_data[0] = 16'd10;
        exp_data[1] = 16'd20;
        exp_data[2] = 16'd30;
        exp_data[3] = 16'd40;
        repeat_mode = 1'b1;
        do_start(9'd4);
        wait_valid("t5_valid");
        for (int k = 0; k < 12; k++) begin
            if (k == 10) repeat_mode = 1'b0;
            chk("t5_data", 32'(m_axis_tdata), 32'(exp_data[k % 4]));
            chk("t5_tlast", 32'(m_axis_tlast), 32'((k % 4) == 3));
            step();
            if ((k % 4) == 3) begin
                chk("t5_done", 32'(done), 32'd1);
                if (k < 11) begin
                    chk("t5_gapless", 32'(m_axis_tvalid), 32'd1);
                end else begin
                    chk("t5_stop_tvalid", 32'(m_axis_tvalid), 32'd0);
                    chk("t5_stop_busy", 32'(busy), 32'd0);
                end
            end else begin
                chk("t5_no_done", 32'(done), 32'd0);
            end
        end
        repeat_mode = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
